debug_step_display: RTL and testbench
=====================================

Name: debug_step_display

Overview:
- Board-level debug controller that sits between the board I/O and the ARM pipeline core.
- Gates the core through a clock-enable, in either free-run or single-step mode. Steps come from a debounced pushbutton.
- Snapshots NUM_CH debug words (PC, instruction, WB value, ...) and shows the switch-selected word in hex on NUM_DIGITS seven-segment displays.
- Generalises the fixed board wrapper: any channel count, word width and digit count, plus a stepping mode.

Parameters:
NUM_CH, 4, number of debug channels
DATA_W, 32, width of each debug word
NUM_DIGITS, 8, number of seven-segment digits driven
DEBOUNCE_CYC, 250000, consecutive stable cycles required to accept a key level (5 ms at 50 MHz)
SEL_W, $clog2(NUM_CH) (minimum 1), channel-select width

Ports:
clk  in  1  system clock (CLOCK_50)
rst  in  1  asynchronous, active-low reset
run_mode  in  1  raw switch: 1 = free run, 0 = halt/step
step_key  in  1  raw pushbutton, active-low (pressed = 0)
ch_sel  in  SEL_W  raw switch: channel to display
dbg_data  in  NUM_CH*DATA_W  debug words; channel k occupies bits [k*DATA_W +: DATA_W]
core_en  out  1  clock enable to the core
hex  out  7*NUM_DIGITS  active-low segments; digit d occupies bits [7*d +: 7], segment order {g,f,e,d,c,b,a}
step_cnt  out  16  count of core_en-high cycles
snap_valid  out  1  high once at least one snapshot has been taken

Behaviour:
- Reset (rst=0, asynchronous):
  - state=HALT, core_en=0, step_cnt=0, snap_valid=0, snapshot=0.
  - Debounced key=1 (released), synchronisers=1 for the key and 0 for run_mode.
  - hex shows "0" on every digit (7'h40 each).
- Input conditioning:
  - run_mode and step_key each pass through a 2-flop synchroniser. ch_sel is used directly (quasi-static).
- Debounce:
  - A counter resets whenever the synced key differs from the debounced key.
  - When the counter reaches DEBOUNCE_CYC, the debounced key takes the synced value and the counter clears.
  - press = 1-cycle pulse on a debounced 1->0 transition. Release generates nothing.
- FSM:
  - HALT: core_en=0. If synced run_mode=1, go to RUN (run has priority over press). Else if press, go to STEP.
  - STEP: core_en=1 for exactly this one cycle. Go to SNAP.
  - SNAP: core_en=0. Capture all of dbg_data into the snapshot, set snap_valid=1. Go to HALT.
  - RUN: core_en=1. Snapshot captures dbg_data every cycle, snap_valid=1. If synced run_mode=0, go to HALT; the capture still happens in that last RUN cycle.
- press pulses in STEP, SNAP or RUN are dropped, not queued.
- A run_mode change during STEP/SNAP takes effect on return to HALT.
- Latency:
  - Key pressed stably at cycle t: press fires at t+2+DEBOUNCE_CYC (±1). core_en is high on the following cycle.
  - Snapshot is updated one cycle after that.
- step_cnt:
  - Increments on every cycle with core_en=1 (STEP and RUN).
  - Wraps 16'hFFFF -> 0.
- Display:
  - Selected word = snapshot channel ch_sel.
  - Zero-extend to NUM_DIGITS*4 bits if DATA_W is smaller; truncate to the low NUM_DIGITS*4 bits if larger.
  - Digit d shows nibble d through a hex-to-7seg decode (0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E).
  - hex is registered: one cycle after a snapshot or ch_sel change.
  - ch_sel >= NUM_CH: all digits blank (7'h7F).

Decomposition:
- Shared package debug_pkg holds:
  - state enum (HALT, STEP, SNAP, RUN);
  - SEG_BLANK constant;
  - 16-entry segment table and hex7seg function.
- Sub-module key_debouncer holds the synchroniser, counter, debounced level and press pulse.
- Parent instantiates it once for step_key. run_mode uses only a plain synchroniser.

Test Plan (DEBOUNCE_CYC=4, NUM_CH=4, DATA_W=32, NUM_DIGITS=8):
1. Reset with rst=0 then 1, run_mode=0, no key activity for 50 cycles -> core_en=0 throughout, step_cnt=0, snap_valid=0, hex=all 7'h40.
2. dbg_data ch1=32'h0000_00A5, ch_sel=1; hold step_key=0 for 10 cycles -> exactly one core_en pulse, step_cnt=1, snap_valid=1, hex digit0=7'h12, digit1=7'h08, digits2-7=7'h40.
3. step_key low for 3 cycles, then bouncing 0/1 each cycle for 20 cycles -> zero core_en pulses, step_cnt stays 0.
4. run_mode=1 for 100 cycles then 0 -> core_en high about 100 cycles, then FSM in HALT with core_en=0. step_cnt matches core_en-high count; snapshot equals dbg_data from the last RUN cycle.
5. Preload 16'hFFFF via RUN (force or long run), then one step -> step_cnt=0. ch_sel=3 shows ch3; with NUM_CH=3 build, ch_sel=3 -> all digits 7'h7F.
6. Assert rst=0 mid-RUN and mid-STEP -> core_en drops to 0 in the same cycle (asynchronous). All outputs return to reset values; after release the FSM is in HALT.

Source files
------------

// File: rtl/debug_pkg.sv
// Shared types and seven-segment decode for the board debug controller.
// Holds the stepping FSM states and the hex digit segment table.
package debug_pkg;

    typedef enum logic [1:0] {
        HALT = 2'd0,
        STEP = 2'd1,
        SNAP = 2'd2,
        RUN  = 2'd3
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_ZERO  = 7'h40;

    // Active-low {g,f,e,d,c,b,a}; entry 15 first, entry 0 last.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46,
        7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19,
        7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [6:0] hex7seg(input logic [3:0] nib);
        return SEG_TABLE[nib];
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// Pushbutton conditioning: 2-flop synchroniser, stability counter,
// debounced level and a one-cycle pulse on each accepted press (1->0).
module key_debouncer #(
    parameter int DEBOUNCE_CYC = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             db_q, db_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Accept a new level only after DEBOUNCE_CYC consecutive differing cycles
    always_comb begin
        sync1_d = key_raw;
        sync2_d = sync1_q;
        db_d    = db_q;
        cnt_d   = '0;
        press_d = 1'b0;
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
                db_d    = sync2_q;
                press_d = ~sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers; the key idles released (high)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            db_q    <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/debug_step_display.sv
// Board debug controller: free-run / single-step clock enable for the
// core, debug word snapshot, and hex display of the selected channel.
module debug_step_display
    import debug_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int DATA_W       = 32,
    parameter int NUM_DIGITS   = 8,
    parameter int DEBOUNCE_CYC = 250000,
    parameter int SEL_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     run_mode,
    input  logic                     step_key,
    input  logic [SEL_W-1:0]         ch_sel,
    input  logic [NUM_CH*DATA_W-1:0] dbg_data,
    output logic                     core_en,
    output logic [7*NUM_DIGITS-1:0]  hex,
    output logic [15:0]              step_cnt,
    output logic                     snap_valid
);

    localparam int DISP_W = NUM_DIGITS * 4;

    state_t                    state_q, state_d;
    logic                      rm_s1_q, rm_s1_d;
    logic                      rm_s2_q, rm_s2_d;
    logic [NUM_CH*DATA_W-1:0]  snap_q, snap_d;
    logic                      snap_valid_q, snap_valid_d;
    logic [15:0]               step_cnt_q, step_cnt_d;
    logic [7*NUM_DIGITS-1:0]   hex_q, hex_d;
    logic                      press;
    logic                      capture;
    logic                      sel_ok;
    logic [DATA_W-1:0]         word;
    logic [DISP_W-1:0]         disp;

    key_debouncer #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_key (
        .clk    (clk),
        .rst    (rst),
        .key_raw(step_key),
        .press  (press)
    );

    // Stepping FSM; run has priority over a press, presses are never queued
    always_comb begin
        state_d = state_q;
        core_en = 1'b0;
        capture = 1'b0;
        rm_s1_d = run_mode;
        rm_s2_d = rm_s1_q;
        unique case (state_q)
            HALT: begin
                if (rm_s2_q) begin
                    state_d = RUN;
                end else if (press) begin
                    state_d = STEP;
                end
            end
            STEP: begin
                core_en = 1'b1;
                state_d = SNAP;
            end
            SNAP: begin
                capture = 1'b1;
                state_d = HALT;
            end
            RUN: begin
                core_en = 1'b1;
                capture = 1'b1;
                if (!rm_s2_q) begin
                    state_d = HALT;
                end
            end
            default: state_d = HALT;
        endcase
        snap_d       = capture ? dbg_data : snap_q;
        snap_valid_d = snap_valid_q | capture;
        step_cnt_d   = step_cnt_q + 16'(core_en);
    end

    // Pick the selected snapshot word; out-of-range selects blank the display
    always_comb begin
        word   = '0;
        sel_ok = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (int'(ch_sel) == k) begin
                word   = snap_q[k*DATA_W +: DATA_W];
                sel_ok = 1'b1;
            end
        end
    end

    if (DATA_W >= DISP_W) begin : g_trunc
        assign disp = word[DISP_W-1:0];
    end else begin : g_zext
        assign disp = {{(DISP_W - DATA_W){1'b0}}, word};
    end

    // Decode every nibble of the displayed word to its segment pattern
    always_comb begin
        hex_d = '0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            hex_d[7*d +: 7] = sel_ok ? hex7seg(disp[4*d +: 4]) : SEG_BLANK;
        end
    end

    // State, snapshot, counter and display registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= HALT;
            rm_s1_q      <= 1'b0;
            rm_s2_q      <= 1'b0;
            snap_q       <= '0;
            snap_valid_q <= 1'b0;
            step_cnt_q   <= '0;
            hex_q        <= {NUM_DIGITS{SEG_ZERO}};
        end else begin
            state_q      <= state_d;
            rm_s1_q      <= rm_s1_d;
            rm_s2_q      <= rm_s2_d;
            snap_q       <= snap_d;
            snap_valid_q <= snap_valid_d;
            step_cnt_q   <= step_cnt_d;
            hex_q        <= hex_d;
        end
    end

    assign hex        = hex_q;
    assign step_cnt   = step_cnt_q;
    assign snap_valid = snap_valid_q;

endmodule

// File: tb/tb_debug_step_display.sv
// Bench for debug_step_display: table vectors, hand sequences for
// debounce/reset corners, and randomized run/step against a model.
module tb_debug_step_display;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         run_mode = 1'b0;
    logic         step_key = 1'b1;
    logic [1:0]   ch_sel = 2'd0;
    logic [127:0] dbg_data = '0;
    logic         core_en, core_en3;
    logic [55:0]  hex, hex3;
    logic [15:0]  step_cnt, step_cnt3;
    logic         snap_valid, snap_valid3;

    int n_chk = 0;
    int n_fail = 0;
    int en_seen = 0;

    logic [31:0] snap_m [4];
    int unsigned cnt_m = 0;

    logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                             7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03,
                             7'h46, 7'h21, 7'h06, 7'h0E};

    typedef struct {
        logic [1:0]  sel;
        logic [55:0] exp4;
        logic [55:0] exp3;
    } vec_t;

    debug_step_display #(
        .NUM_CH(4), .DATA_W(32), .NUM_DIGITS(8), .DEBOUNCE_CYC(4)
    ) dut (
        .clk(clk), .rst(rst), .run_mode(run_mode), .step_key(step_key),
        .ch_sel(ch_sel), .dbg_data(dbg_data), .core_en(core_en),
        .hex(hex), .step_cnt(step_cnt), .snap_valid(snap_valid)
    );

    debug_step_display #(
        .NUM_CH(3), .DATA_W(32), .NUM_DIGITS(8), .DEBOUNCE_CYC(4)
    ) dut3 (
        .clk(clk), .rst(rst), .run_mode(run_mode), .step_key(step_key),
        .ch_sel(ch_sel), .dbg_data(dbg_data[95:0]), .core_en(core_en3),
        .hex(hex3), .step_cnt(step_cnt3), .snap_valid(snap_valid3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (core_en) en_seen <= en_seen + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [55:0] exp_hex(input logic [31:0] w,
                                            input bit blank);
        logic [55:0] r;
        logic [3:0]  nib;
        for (int d = 0; d < 8; d++) begin
            nib = 4'((w >> (4 * d)) & 32'hF);
            r[7*d +: 7] = blank ? 7'h7F : SEG[nib];
        end
        return r;
    endfunction

    task automatic set_words(input logic [31:0] w0, input logic [31:0] w1,
                             input logic [31:0] w2, input logic [31:0] w3);
        dbg_data = {w3, w2, w1, w0};
    endtask

    task automatic latch_model();
        for (int k = 0; k < 4; k++) snap_m[k] = dbg_data[32*k +: 32];
    endtask

    task automatic do_step();
        step_key = 1'b0;
        repeat (12) tick();
        step_key = 1'b1;
        repeat (12) tick();
        cnt_m = (cnt_m + 1) % 65536;
        latch_model();
    endtask

    task automatic run_burst(input int n);
        run_mode = 1'b1;
        repeat (n) tick();
        run_mode = 1'b0;
        repeat (6) tick();
        cnt_m = (cnt_m + n) % 65536;
        latch_model();
    endtask

    task automatic chk_sel(input string name, input logic [1:0] s);
        ch_sel = s;
        tick();
        tick();
        chk({name, "_hex"}, 64'(hex), 64'(exp_hex(snap_m[s], 1'b0)));
        chk({name, "_hex3"}, 64'(hex3), 64'(exp_hex(snap_m[s], s == 2'd3)));
    endtask

    task automatic chk_cnt(input string name);
        chk({name, "_cnt"}, 64'(step_cnt), 64'(cnt_m));
        chk({name, "_cnt3"}, 64'(step_cnt3), 64'(cnt_m));
    endtask

    task automatic chk_reset_vals(input string name);
        chk({name, "_en"}, 64'({core_en, core_en3}), 64'd0);
        chk({name, "_cnt"}, 64'({step_cnt, step_cnt3}), 64'd0);
        chk({name, "_valid"}, 64'({snap_valid, snap_valid3}), 64'd0);
        chk({name, "_hex"}, 64'(hex), 64'({8{7'h40}}));
        chk({name, "_hex3"}, 64'(hex3), 64'({8{7'h40}}));
    endtask

    initial begin
        vec_t vt [4];
        int   e0;
        int   n;
        bit   hit;
        logic [31:0] w [4];

        vt[0] = '{2'd0, {7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78},
                        {7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78}};
        vt[1] = '{2'd1, {7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E},
                        {7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E}};
        vt[2] = '{2'd2, {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h08, 7'h12},
                        {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h08, 7'h12}};
        vt[3] = '{2'd3, {7'h21, 7'h06, 7'h08, 7'h21, 7'h03, 7'h06, 7'h06, 7'h0E},
                        {8{7'h7F}}};

        for (int k = 0; k < 4; k++) snap_m[k] = '0;

        // 1: reset and idle
        repeat (3) tick();
        rst = 1'b1;
        chk_reset_vals("reset");
        e0 = en_seen;
        repeat (50) tick();
        chk("idle_pulses", 64'(en_seen - e0), 64'd0);
        chk_reset_vals("idle");

        // 2: single step shows channel 1 = 0xA5
        set_words(32'h0, 32'h0000_00A5, 32'h0, 32'h0);
        ch_sel = 2'd1;
        e0 = en_seen;
        do_step();
        chk("step_pulses", 64'(en_seen - e0), 64'd1);
        chk_cnt("step");
        chk("step_valid", 64'({snap_valid, snap_valid3}), 64'h3);
        chk("step_dig0", 64'(hex[6:0]), 64'h12);
        chk("step_dig1", 64'(hex[13:7]), 64'h08);
        chk("step_hi", 64'(hex[55:14]), 64'({6{7'h40}}));

        // 3: short low then bouncing key never yields a step
        e0 = en_seen;
        step_key = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 20; i++) begin
            step_key = (i % 2 == 0);
            tick();
        end
        step_key = 1'b1;
        repeat (12) tick();
        chk("bounce_pulses", 64'(en_seen - e0), 64'd0);
        chk_cnt("bounce");

        // table: known words, every channel on both builds
        set_words(32'h0123_4567, 32'h89AB_CDEF, 32'h0000_00A5, 32'hDEAD_BEEF);
        do_step();
        for (int i = 0; i < 4; i++) begin
            ch_sel = vt[i].sel;
            tick();
            tick();
            chk($sformatf("tbl%0d_hex", i), 64'(hex), 64'(vt[i].exp4));
            chk($sformatf("tbl%0d_hex3", i), 64'(hex3), 64'(vt[i].exp3));
        end

        // 4: 100-cycle run with data changing every cycle
        e0 = en_seen;
        n = 100;
        run_mode = 1'b1;
        for (int i = 1; i <= n + 3; i++) begin
            tick();
            if (i == n) run_mode = 1'b0;
            if (i <= n + 2) begin
                for (int k = 0; k < 4; k++) w[k] = $urandom;
                set_words(w[0], w[1], w[2], w[3]);
            end
        end
        latch_model();
        cnt_m = (cnt_m + n) % 65536;
        set_words(~w[0], ~w[1], ~w[2], ~w[3]);
        repeat (4) tick();
        chk("run_pulses", 64'(en_seen - e0), 64'(n));
        chk("run_halt_en", 64'({core_en, core_en3}), 64'd0);
        chk_cnt("run");
        for (int s = 0; s < 4; s++) chk_sel($sformatf("run_ch%0d", s), 2'(s));

        // random run bursts and steps against the model
        for (int it = 0; it < 16; it++) begin
            set_words($urandom, $urandom, $urandom, $urandom);
            if ($urandom_range(0, 1) == 1) run_burst($urandom_range(1, 30));
            else do_step();
            chk_cnt($sformatf("rnd%0d", it));
            chk_sel($sformatf("rnd%0d", it), 2'($urandom_range(0, 3)));
        end

        // 5: counter wrap via a long run then one step
        rst = 1'b0;
        tick();
        rst = 1'b1;
        cnt_m = 0;
        set_words(32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 32'h7777_8888);
        run_burst(65535);
        chk_cnt("pre_wrap");
        do_step();
        chk_cnt("wrap");
        chk_sel("wrap_ch3", 2'd3);
        chk_sel("wrap_ch2", 2'd2);

        // 6: asynchronous reset mid-RUN
        run_mode = 1'b1;
        repeat (10) tick();
        chk("midrun_en", 64'({core_en, core_en3}), 64'h3);
        #2 rst = 1'b0;
        #1;
        chk_reset_vals("rst_run");
        run_mode = 1'b0;
        tick();
        rst = 1'b1;
        e0 = en_seen;
        repeat (10) tick();
        chk("post_run_pulses", 64'(en_seen - e0), 64'd0);

        // 6: asynchronous reset mid-STEP
        step_key = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            tick();
            hit = core_en;
        end
        chk("step_seen", 64'(hit), 64'd1);
        #2 rst = 1'b0;
        #1;
        chk_reset_vals("rst_step");
        step_key = 1'b1;
        tick();
        rst = 1'b1;
        e0 = en_seen;
        repeat (12) tick();
        chk("post_step_pulses", 64'(en_seen - e0), 64'd0);
        chk_reset_vals("post_step");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
